// File: rtl/rrat.sv
// Retirement register alias table: per-thread committed architectural-to-physical map,
// releasing superseded PRNs at commit and publishing the committed map and free list.
module rrat #(
  parameter int AR_SIZE = 32,
  parameter int AR_BITS = 5,
  parameter int PR_SIZE = 64,
  parameter int PR_BITS = 6
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [3:0]                             commit_valid,
  input  logic [3:0][AR_BITS-1:0]                commit_ARN,
  input  logic [3:0][PR_BITS-1:0]                commit_PRN,
  output logic [3:0][PR_BITS-1:0]                free_PRN_out,
  output logic [1:0][PR_SIZE-1:0]                RRAT_free_list,
  output logic [1:0][AR_SIZE-1:0][PR_BITS-1:0]   arch_map_out,
  output logic [1:0][31:0]                       commit_count
);

  localparam logic [AR_BITS-1:0] ZERO_ARN = AR_BITS'(AR_SIZE - 1);
  localparam logic [PR_BITS-1:0] ZERO_PRN = PR_BITS'(PR_SIZE - 1);

  function automatic logic [31:0] count_inc(input logic [31:0] cnt, input logic v_lo,
                                            input logic v_hi);
    return cnt + 32'(v_lo) + 32'(v_hi);
  endfunction

  function automatic logic [PR_BITS-1:0] release_prn(input logic rst, input logic act,
                                                     input logic [PR_BITS-1:0] old);
    return (!rst && act && old != ZERO_PRN) ? old : ZERO_PRN;
  endfunction

  for (genvar t = 0; t < 2; t++) begin : g_thread
    localparam int LO = 2 * t;
    localparam int HI = 2 * t + 1;

    logic [AR_SIZE-1:0][PR_BITS-1:0] r_map;
    logic [AR_SIZE-1:0][PR_BITS-1:0] w_map_nxt;
    logic [31:0]                     r_count;
    logic                            w_act_lo;
    logic                            w_act_hi;
    logic [PR_BITS-1:0]              w_old_lo;
    logic [PR_BITS-1:0]              w_old_hi;
    logic [AR_SIZE-1:0][PR_SIZE-1:0] w_hit;
    logic [AR_SIZE:0][PR_SIZE-1:0]   w_acc;

    assign w_act_lo = commit_valid[LO] && (commit_ARN[LO] != ZERO_ARN);
    assign w_act_hi = commit_valid[HI] && (commit_ARN[HI] != ZERO_ARN);

    // The younger port sees the older port's same-cycle write as its previous mapping.
    assign w_old_lo = r_map[commit_ARN[LO]];
    assign w_old_hi = (w_act_lo && commit_ARN[HI] == commit_ARN[LO]) ? commit_PRN[LO]
                                                                     : r_map[commit_ARN[HI]];

    assign free_PRN_out[LO] = release_prn(reset, w_act_lo, w_old_lo);
    assign free_PRN_out[HI] = release_prn(reset, w_act_hi, w_old_hi);

    assign w_acc[0] = '0;
    for (genvar a = 0; a < AR_SIZE; a++) begin : g_arn
      always_comb begin
        w_map_nxt[a] = r_map[a];
        if (reset)
          w_map_nxt[a] = ZERO_PRN;
        else if (w_act_hi && commit_ARN[HI] == AR_BITS'(a))
          w_map_nxt[a] = commit_PRN[HI];
        else if (w_act_lo && commit_ARN[LO] == AR_BITS'(a))
          w_map_nxt[a] = commit_PRN[LO];
      end
      assign w_hit[a]   = PR_SIZE'(1) << w_map_nxt[a];
      assign w_acc[a+1] = w_acc[a] | w_hit[a];
    end

    // The zero register is never allocatable, so it never shows as free.
    assign RRAT_free_list[t] = ~w_acc[AR_SIZE] & ~(PR_SIZE'(1) << ZERO_PRN);
    assign arch_map_out[t]   = w_map_nxt;
    assign commit_count[t]   = r_count;

    always_ff @(posedge clock) begin
      r_map <= w_map_nxt;
      if (reset)
        r_count <= '0;
      else
        r_count <= count_inc(r_count, commit_valid[LO], commit_valid[HI]);
    end
  end

endmodule

// File: doc/rrat.md
RRAT -- requirements
Module: rrat

Interface
REQ-001 SHALL have parameter AR_SIZE, default 32: architectural registers per thread.
REQ-002 SHALL have parameter AR_BITS, default 5: width of an architectural register number.
REQ-003 SHALL have parameter PR_SIZE, default 64: physical registers; PRN PR_SIZE-1 is the permanent zero register.
REQ-004 SHALL have parameter PR_BITS, default 6: width of a PRN.
REQ-005 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port commit_valid  input  [3:0]  commit port valid; ports 0-1 are thread 0, ports 2-3 are thread 1; the lower port is older within a thread.
REQ-008 SHALL have port commit_ARN  input  [3:0][AR_BITS-1:0]  destination architectural register per commit port.
REQ-009 SHALL have port commit_PRN  input  [3:0][PR_BITS-1:0]  destination PRN per commit port.
REQ-010 SHALL have port free_PRN_out  output  [3:0][PR_BITS-1:0]  PRN released per commit port; value PR_SIZE-1 means nothing released; feeds the PRF free_PRN_in.
REQ-011 SHALL have port RRAT_free_list  output  [1:0][PR_SIZE-1:0]  per thread, bit i=1 when PRN i is not referenced by that thread's committed map.
REQ-012 SHALL have port arch_map_out  output  [1:0][AR_SIZE-1:0][PR_BITS-1:0]  per-thread committed map used for RAT recovery.
REQ-013 SHALL have port commit_count  output  [1:0][31:0]  per-thread count of retired instructions, registered.

Function
REQ-014 SHALL hold two state maps, map[t][a] (PR_BITS each), plus two 32-bit counters.
REQ-015 SHALL treat a port as active when commit_valid=1 and commit_ARN != AR_SIZE-1. A port with commit_ARN = AR_SIZE-1 SHALL leave the map unchanged and SHALL drive free_PRN_out = PR_SIZE-1.
REQ-016 For each active port, the old PRN SHALL be released on free_PRN_out, combinationally in the same cycle. The old PRN is map[t][ARN] as updated by the older port of the same thread.
REQ-017 For each active port, map[t][ARN] SHALL take the value commit_PRN at the next edge.
REQ-018 Both ports of one thread targeting the same ARN: port hi's old PRN = port lo's commit_PRN, port lo frees the prior mapping, and the final map value = port hi's commit_PRN.
REQ-019 An old PRN equal to PR_SIZE-1 SHALL NOT be released; drive PR_SIZE-1 on that port instead.
REQ-020 Inactive or invalid ports SHALL drive free_PRN_out = PR_SIZE-1.
REQ-021 arch_map_out and RRAT_free_list SHALL be computed combinationally from the next-state map, so they include same-cycle commits.
REQ-022 RRAT_free_list[t][PR_SIZE-1] SHALL always be 0.
REQ-023 commit_count[t] SHALL increment by the number of valid ports of thread t (0/1/2), including ARN = AR_SIZE-1 ports, and SHALL wrap modulo 2^32.
REQ-024 Threads SHALL be fully independent; commits on one thread never alter the other thread's map.

Reset
REQ-025 On reset, every map[t][a] SHALL be set to PR_SIZE-1 and commit_count SHALL be set to 0.
REQ-026 During a reset cycle, commit inputs SHALL be ignored and free_PRN_out SHALL be PR_SIZE-1 on all ports.
REQ-027 After reset, RRAT_free_list[t] SHALL equal all ones except bit PR_SIZE-1.
REQ-028 A reset asserted mid-stream SHALL discard all maps; there SHALL be no partial update.

Verification
REQ-029 Reset, then port0 commit ARN3->PRN5 -> free_PRN_out[0]=63 (zero register not freed); next cycle arch_map_out[0][3]=5 and RRAT_free_list[0][5]=0.
REQ-030 Then port0 commit ARN3->PRN9 -> free_PRN_out[0]=5 that cycle; next map[0][3]=9 and RRAT_free_list[0][5]=1.
REQ-031 Same cycle, port0 ARN4->PRN10 and port1 ARN4->PRN11 (map[0][4]=63) -> free[0]=63, free[1]=10; final map[0][4]=11; commit_count[0]+=2.
REQ-032 Port2 ARN3->PRN20 while map[0][3]=9 -> free[2]=63; thread-0 map unchanged; RRAT_free_list[1][20]=0 in the same cycle; RRAT_free_list[0][20]=1.
REQ-033 Port0 with commit_ARN=31 and commit_PRN=12 -> free[0]=63; map unchanged; commit_count[0]+=1.
REQ-034 Assert reset while all four ports commit -> next cycle all maps=63, counts=0, and free outputs=63 during the reset cycle.
